top_design: RTL and testbench

TOP_DESIGN -- requirements
Module: top_design

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_if.sv | 14 +
 rtl/vga_sync.sv | 71 +++++++
 rtl/top_design.sv | 69 ++++++
 tb/tb_top_design.sv | 135 +++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and helpers for the frame geometry derived from
// the per-instance porch/sync parameters.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned CLK_DIV_DEF  = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int unsigned total(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned act, input int unsigned fp);
    return act + fp;
  endfunction

  function automatic int unsigned sync_last(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync);
    return act + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Timing bus from the sync generator to the output stage.
interface vga_if;
  import vga_pkg::*;

  logic pixel_tick;
  cnt_t h_count;
  cnt_t v_count;
  logic video_on;
  logic h_sync_n;
  logic v_sync_n;

  modport master (output pixel_tick, h_count, v_count, video_on, h_sync_n, v_sync_n);
  modport slave  (input  pixel_tick, h_count, v_count, video_on, h_sync_n, v_sync_n);
endinterface

// File: rtl/vga_sync.sv
// Pixel-clock divider, horizontal/vertical counters and combinational
// sync / video_on decode of the current counter values.
module vga_sync
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF
) (
  input  logic  i_clk,
  input  logic  i_rst,
  vga_if.master tbus
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam cnt_t        H_LAST  = cnt_t'(total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam cnt_t        V_LAST  = cnt_t'(total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam cnt_t        HS_LO   = cnt_t'(sync_first(H_ACTIVE, H_FP));
  localparam cnt_t        HS_HI   = cnt_t'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam cnt_t        VS_LO   = cnt_t'(sync_first(V_ACTIVE, V_FP));
  localparam cnt_t        VS_HI   = cnt_t'(sync_last(V_ACTIVE, V_FP, V_SYNC));
  localparam cnt_t        H_VIS   = cnt_t'(H_ACTIVE);
  localparam cnt_t        V_VIS   = cnt_t'(V_ACTIVE);

  logic [DIV_W-1:0] div_q, div_d;
  cnt_t             h_q, h_d;
  cnt_t             v_q, v_d;
  logic             tick;

  always_comb begin
    tick  = (div_q == DIV_W'(CLK_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    // v advances only on the same tick that wraps h
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign tbus.pixel_tick = tick;
  assign tbus.h_count    = h_q;
  assign tbus.v_count    = v_q;
  assign tbus.video_on   = (h_q < H_VIS) && (v_q < V_VIS);
  assign tbus.h_sync_n   = !((h_q >= HS_LO) && (h_q <= HS_HI));
  assign tbus.v_sync_n   = !((v_q >= VS_LO) && (v_q <= VS_HI));

endmodule

// File: rtl/top_design.sv
// VGA timing generator top: registers sync outputs and gates the incoming
// pixel colour to black outside the visible area.
module top_design
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] d_in,
  output logic        H_sync,
  output logic        V_sync,
  output logic [11:0] RGB_out
);

  vga_if tbus ();

  vga_sync #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst_n),
    .tbus  (tbus)
  );

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    hs_d  = tbus.h_sync_n;
    vs_d  = tbus.v_sync_n;
    rgb_d = tbus.video_on ? d_in : '0;
  end

  // i_rst_n is active-high despite its name
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign H_sync  = hs_q;
  assign V_sync  = vs_q;
  assign RGB_out = rgb_q;

endmodule

// File: tb/tb_top_design.sv
// Randomized bench for top_design on a shrunken raster; expected values come
// from the clock count since reset release using plain integer arithmetic.
module tb_top_design;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int unsigned DIV = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] d_in = '0;
  logic        h_sync;
  logic        v_sync;
  logic [11:0] rgb_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned k = 0;
  int unsigned hs_low = 0;
  int unsigned vs_low = 0;
  int unsigned rgb_lit = 0;

  vga_if ref_bus ();

  top_design #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CLK_DIV  (DIV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst),
    .d_in    (d_in),
    .H_sync  (h_sync),
    .V_sync  (v_sync),
    .RGB_out (rgb_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d after release, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic int unsigned pix_h(input int unsigned edges);
    return (edges / DIV) % HT;
  endfunction

  function automatic int unsigned pix_v(input int unsigned edges);
    return (edges / DIV / HT) % VT;
  endfunction

  // One clock: drive inputs, predict registered outputs from the raster
  // position before the edge, then compare outputs and internal timing bus.
  task automatic step(input logic r, input logic [11:0] d);
    int unsigned h, v;
    logic        exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    rst  = r;
    d_in = d;
    h = pix_h(k);
    v = pix_v(k);
    exp_hs  = !(h >= HA + HF && h < HA + HF + HS);
    exp_vs  = !(v >= VA + VF && v < VA + VF + VS);
    exp_rgb = (h < HA && v < VA) ? d : 12'h000;
    if (r) begin
      exp_hs  = 1'b1;
      exp_vs  = 1'b1;
      exp_rgb = 12'h000;
    end
    @(posedge clk);
    #1;
    k = r ? 0 : k + 1;
    check_eq("H_sync", h_sync, exp_hs);
    check_eq("V_sync", v_sync, exp_vs);
    check_eq("RGB_out", rgb_out, exp_rgb);
    if (!h_sync) hs_low++;
    if (!v_sync) vs_low++;
    if (rgb_out != 12'h000) rgb_lit++;

    h = pix_h(k);
    v = pix_v(k);
    ref_bus.pixel_tick = ((k % DIV) == DIV - 1);
    ref_bus.h_count    = 10'(h);
    ref_bus.v_count    = 10'(v);
    ref_bus.video_on   = (h < HA && v < VA);
    ref_bus.h_sync_n   = !(h >= HA + HF && h < HA + HF + HS);
    ref_bus.v_sync_n   = !(v >= VA + VF && v < VA + VF + VS);
    check_eq("pixel_tick", dut.tbus.pixel_tick, ref_bus.pixel_tick);
    check_eq("h_count", dut.tbus.h_count, ref_bus.h_count);
    check_eq("v_count", dut.tbus.v_count, ref_bus.v_count);
    check_eq("video_on", dut.tbus.video_on, ref_bus.video_on);
    check_eq("h_sync_n", dut.tbus.h_sync_n, ref_bus.h_sync_n);
    check_eq("v_sync_n", dut.tbus.v_sync_n, ref_bus.v_sync_n);
  endtask

  initial begin
    step(1'b1, 12'($urandom));
    step(1'b1, 12'($urandom));
    step(1'b0, 12'h223);
    check_eq("first_rgb", rgb_out, 12'h223);

    // one clean frame from release: count sync-low clocks and lit pixels
    hs_low  = (!h_sync) ? 1 : 0;
    vs_low  = (!v_sync) ? 1 : 0;
    rgb_lit = 1;
    for (int unsigned i = 1; i < FRAME; i++) step(1'b0, 12'h710);
    check_eq("hs_low_frame", hs_low, HS * DIV * VT);
    check_eq("vs_low_frame", vs_low, VS * HT * DIV);
    check_eq("rgb_lit_frame", rgb_lit, HA * VA * DIV);

    for (int unsigned i = 0; i < FRAME + 2 * HT * DIV; i++) step(1'b0, 12'($urandom));

    // mid-frame reset at pixel (5,3)
    while (pix_h(k) != 5 || pix_v(k) != 3) step(1'b0, 12'($urandom));
    step(1'b1, 12'($urandom));
    check_eq("rst_h_count", dut.tbus.h_count, 0);
    check_eq("rst_v_count", dut.tbus.v_count, 0);
    for (int unsigned i = 0; i < FRAME + 40; i++) step(1'b0, 12'($urandom));

    // random short resets scattered across a couple of frames
    for (int unsigned i = 0; i < 2 * FRAME; i++)
      step(($urandom_range(0, 149) == 0), 12'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
